regfile_scoreboard: RTL

//  Issue-stage hazard controller for the 32x32 integer register file. Tracks outstanding

---
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Issue-stage scoreboard for the 32x32 integer register file. It counts outstanding writes per
// register and stalls issue on RAW hazards, or when a destination counter is already at its maximum.
// Optional build macro SCOREBOARD_BYPASS_EN: a hazard resolved by a same-cycle final writeback is cancelled.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int TOT_W    = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rs1,
  input  logic [4:0]          issue_rs2,
  input  logic [4:0]          issue_rd,
  input  logic                issue_rd_write,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [TOT_W-1:0]    outstanding_total,
  output logic                wb_error
);

  localparam int KEY_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic                raw1;
  logic                raw2;
  logic                waw_full;
  logic                issue_fire;
  logic                alloc;
  logic                retire;
  logic                wb_zero;
  logic [NUM_REGS-1:0] alloc_hit;
  logic [NUM_REGS-1:0] retire_hit;

  // Hazard detection against the current counters; ready is held low during reset and flush.
  always_comb begin
    raw1     = (issue_rs1 != '0) && (cnt[issue_rs1] != '0);
    raw2     = (issue_rs2 != '0) && (cnt[issue_rs2] != '0);
    waw_full = issue_rd_write && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
`ifdef SCOREBOARD_BYPASS_EN
    // The last outstanding write lands this cycle and is forwarded to the read port.
    if (wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == CNT_ONE)) raw1 = 1'b0;
    if (wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == CNT_ONE)) raw2 = 1'b0;
    // A retirement to the full destination frees one slot in the same cycle.
    if (wb_valid && (wb_rd == issue_rd)) waw_full = 1'b0;
`endif
    issue_ready = reset_n && !flush && !(raw1 || raw2 || waw_full);
  end

  // Decode allocation and retirement into per-register strobes; key 0 never matches either.
  always_comb begin
    issue_fire = issue_valid && issue_ready;
    alloc      = issue_fire && issue_rd_write && (issue_rd != '0);
    retire     = wb_valid && (wb_rd != '0) && (cnt[wb_rd] != '0);
    wb_zero    = wb_valid && (wb_rd != '0) && (cnt[wb_rd] == '0);
    alloc_hit  = '0;
    retire_hit = '0;
    busy_mask  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      alloc_hit[i]  = alloc && (issue_rd == KEY_W'(i));
      retire_hit[i] = retire && (wb_rd == KEY_W'(i));
      busy_mask[i]  = (cnt[i] != '0);
    end
  end

  // Per-register counters: alloc and retire on one key cancel; flush clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (alloc_hit[i] && !retire_hit[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (retire_hit[i] && !alloc_hit[i]) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

  // Running total tracks the counter sum without an adder tree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_total <= '0;
    end else if (flush) begin
      outstanding_total <= '0;
    end else begin
      outstanding_total <= outstanding_total + TOT_W'(alloc) - TOT_W'(retire);
    end
  end

  // Sticky error for a writeback to an idle register; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_error <= 1'b0;
    end else if (!flush && wb_zero) begin
      wb_error <= 1'b1;
    end
  end

endmodule
